// File: rtl/mse_cost_accum_pkg.sv
// Shared defaults and saturation helpers for the training-datapath cost units.
package dnn_pkg;

    localparam int W_DEF     = 16;
    localparam int FRAC_DEF  = 10;
    localparam int ACC_W_DEF = 24;

    // Clamp a signed value to the range of a w-bit signed number (w < 64).
    function automatic logic signed [63:0] sat_sw(input logic signed [63:0] x,
                                                  input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
    endfunction

    // Unsigned add clamped to 2^w - 1 (w < 64). The sum is formed one bit
    // wider so that it cannot wrap before the compare.
    function automatic logic [63:0] sat_add_u(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input int unsigned w);
        logic [64:0] s;
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        s     = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max_v}) begin
            return max_v;
        end else begin
            return s[63:0];
        end
    endfunction

endpackage

// File: rtl/mse_cost_accum_tgt_regfile.sv
// Target value table: DEPTH x W flops, sync write, async read.
// A read of the entry being written in the same cycle returns the old value.
module tgt_regfile #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wren,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [W-1:0]     o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Table storage; every entry clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wren) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mse_cost_accum.sv
// Squared-error cost unit: target - input error stream, squared and scaled
// back to fixed point, accumulated into a saturating per-batch cost.
module mse_cost_accum
    import dnn_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int DEPTH = 4,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             tgt_wren,
    input  logic [IDX_W-1:0] tgt_waddr,
    input  logic [W-1:0]     tgt_wdata,
    input  logic [CNT_W-1:0] batch_len,
    input  logic             stop,
    input  logic             clear,
    output logic             err_valid,
    output logic [W-1:0]     err_out,
    output logic [ACC_W-1:0] acc_out,
    output logic             cost_done,
    output logic [ACC_W-1:0] cost_out
);

    logic [W-1:0]        w_tgt;
    logic                w_fire;
    logic signed [W:0]   w_diff;
    logic signed [63:0]  w_diff64;
    logic signed [63:0]  w_sat64;

    logic                r_err_valid;
    logic signed [W-1:0] r_err_out;

    logic signed [2*W-1:0] w_sq;
    logic [63:0]         w_sq64;
    logic [63:0]         w_sqs64;
    logic [63:0]         w_sum64;
    logic [ACC_W-1:0]    w_sum;
    logic [CNT_W-1:0]    w_len_m1;
    logic                w_close;

    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_cost_done;
    logic [ACC_W-1:0]    r_cost_out;

    logic                w_unused_bits;

    tgt_regfile #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_tgt_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wren  (tgt_wren),
        .i_waddr (tgt_waddr),
        .i_wdata (tgt_wdata),
        .i_raddr (in_idx),
        .o_rdata (w_tgt)
    );

    // Stage-1 error: one extra bit so target - input cannot overflow before
    // it is clamped back to W bits.
    assign w_fire   = in_valid && !stop && !clear;
    assign w_diff   = {w_tgt[W-1], w_tgt} - {in_data[W-1], in_data};
    assign w_diff64 = {{(63-W){w_diff[W]}}, w_diff};
    assign w_sat64  = sat_sw(w_diff64, W);

    // Stage 1: capture the saturated error; err_out holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_valid <= 1'b0;
            r_err_out   <= '0;
        end else begin
            r_err_valid <= w_fire;
            if (w_fire) begin
                r_err_out <= w_sat64[W-1:0];
            end
        end
    end

    // Stage-2 arithmetic: the square is non-negative, so the logical shift
    // truncates toward zero.
    assign w_sq     = r_err_out * r_err_out;
    assign w_sq64   = {{(64-2*W){1'b0}}, w_sq};
    assign w_sqs64  = w_sq64 >> FRAC;
    assign w_sum64  = sat_add_u({{(64-ACC_W){1'b0}}, r_acc}, w_sqs64, ACC_W);
    assign w_sum    = w_sum64[ACC_W-1:0];
    assign w_len_m1 = batch_len - CNT_W'(1);
    assign w_close  = (batch_len != '0) && (r_cnt == w_len_m1);

    // Stage 2: accumulate, count samples and close the batch. A clear also
    // discards whatever is sitting in stage 1 this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_cost_done <= 1'b0;
            r_cost_out  <= '0;
        end else if (clear) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_cost_done <= 1'b0;
        end else begin
            r_cost_done <= 1'b0;
            if (r_err_valid) begin
                if (w_close) begin
                    r_cost_out  <= w_sum;
                    r_cost_done <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign w_unused_bits = ^{w_sat64[63:W], w_sum64[63:ACC_W]};

    assign err_valid = r_err_valid;
    assign err_out   = r_err_out;
    assign acc_out   = r_acc;
    assign cost_done = r_cost_done;
    assign cost_out  = r_cost_out;

endmodule

// File: doc/mse_cost_accum.md
# mse_cost_accum

Parametrised squared-error cost unit for the training datapath. It holds a small writable table of target values and subtracts each incoming network output from the selected target, giving a signed error. The error is squared, scaled back to fixed point and accumulated into a saturating cost. The cost closes every `BATCH_LEN` samples, which gives the training controller per-batch cost plus a per-sample error stream for back-propagation.

## Interface
Parameters:
- `W`, 16, data and target width (signed fixed point).
- `FRAC`, 10, fractional bits of the `W`-bit format.
- `DEPTH`, 4, number of target entries (power of two, at least 2).
- `ACC_W`, 24, cost accumulator width (unsigned).
- `CNT_W`, 8, width of the batch-length and sample counters.

Ports (clock and reset first):
- `clk`  in  1  single clock, all state on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  sample present this cycle.
- `in_data`  in  W  signed network output.
- `in_idx`  in  log2(DEPTH)  target entry selected for this sample.
- `tgt_wren`  in  1  target table write enable.
- `tgt_waddr`  in  log2(DEPTH)  target write index.
- `tgt_wdata`  in  W  signed target value.
- `batch_len`  in  CNT_W  samples per batch; 0 means the batch never closes.
- `stop`  in  1  freeze; new samples are not accepted.
- `clear`  in  1  synchronous flush of the accumulator, counter and pipeline.
- `err_valid`  out  1  `err_out` is valid.
- `err_out`  out  W  registered saturated error (target − input).
- `acc_out`  out  ACC_W  live running cost.
- `cost_done`  out  1  one-cycle pulse when a batch closes.
- `cost_out`  out  ACC_W  cost of the last closed batch; held until the next close.

## Operation
- Stage 1 captures a sample when `in_valid && !stop && !clear`. It computes `d = tgt[in_idx] − in_data` in W+1 bits, saturates d to the signed W-bit range, registers the result as `err_out` and sets `err_valid` to 1. In every other cycle `err_valid` is 0 and `err_out` holds its value.
- Stage 2 runs when `err_valid` is 1:
  - `sq = err_out*err_out`, 2W bits, never negative.
  - `sqs = sq >> FRAC`, truncated toward zero.
  - `acc` is set to `min(acc + sqs, 2^ACC_W − 1)`; the sum is computed without wraparound.
  - The sample counter `cnt` increments.
- Batch close happens when `batch_len != 0` and `cnt == batch_len − 1` during a stage-2 update:
  - `cost_out` is set to the saturated `acc + sqs`.
  - `cost_done` is 1 for that cycle.
  - `acc` and `cnt` both go to 0.
- With `batch_len == 0`, `cnt` wraps freely and `acc` accumulates until `clear` (free-running mode).
- `clear` zeroes `acc`, `cnt` and the stage-1 valid bit. `cost_out` and the target table are kept. When `clear` and `in_valid` are asserted together, the sample is dropped. A sample already held in stage 1 when `clear` arrives is discarded and not accumulated.
- `stop` blocks only stage-1 capture. A sample already in stage 1 still completes stage 2.
- Target table:
  - A write takes effect at the clock edge.
  - A same-cycle read of the written index returns the old value.
  - Every entry resets to 0.
- Changing `batch_len` in the middle of a batch takes effect at the next compare. If `cnt` is already at or above the new `batch_len − 1`, the batch does not close until `cnt` wraps.

## Timing
- Values while `rst_n` is low, asynchronous:
  - `err_valid` = 0, `err_out` = 0.
  - `acc_out` = 0, `cnt` = 0.
  - `cost_done` = 0, `cost_out` = 0.
  - all target entries = 0.
- A reset in the middle of a batch discards the partial cost. There is no recovery path.
- Latency:
  - `in_valid` at cycle t gives `err_valid`/`err_out` at t+1.
  - The same sample appears in `acc_out` at t+2.
  - If that sample closes the batch, `cost_done`/`cost_out` are valid at t+2.
- Throughput is one sample per cycle, with no backpressure.
- `cost_done` is never high for two consecutive cycles unless `batch_len == 1`.

## Structure
- Package `dnn_pkg`:
  - default values for `W`, `FRAC`, `ACC_W`.
  - function `sat_sw(x, W)`: signed saturation.
  - function `sat_add_u`: unsigned saturating add.
- One sub-module, `tgt_regfile`: DEPTH×W storage with async read, sync write and async active-low reset. The subtractor, square, accumulator and counter live in the top module.

## Test plan
- Basic case: write `tgt[0]=0x1600`, send `in=0x1200` idx 0 → `err_out=0x0400` at t+1; `acc_out=0x000400` at t+2.
- Batch close: `batch_len=3`, three samples each with error 0x0400 → `cost_done` pulses once, `cost_out=0x000C00`, `acc_out` returns to 0; the next sample gives `acc_out=0x000400`.
- Saturation: `tgt=0x7FFF`, `in=0x8000`, `batch_len=0`:
  - `err_out=0x7FFF`.
  - After 16 samples `acc_out=0xFFFC00`.
  - After the 17th sample `acc_out=0xFFFFFF`, and it stays there.
- `stop` and `clear`:
  - Samples sent while `stop=1` change nothing.
  - `clear` together with `in_valid` → sample dropped, `acc_out=0`, `cost_out` unchanged.
- Write/read collision: write `tgt[2]=0x0680` in the same cycle as a sample on idx 2 with `in=0` → the error uses the old value 0; the next sample gives `err_out=0x0680`.
- Reset: pull `rst_n` low mid-batch, between edges → all outputs 0 immediately; after release, the table reads 0.
